pifo_req_dispatcher: RTL and testbench

Per-level request front end that sits directly upstream of one level port of the PIFO SRAM top (`i_push`/`i_pop`/`i_tree_id`/`i_push_data`). It buffers push/pop requests from the tenant side in a small in-order queue. It tracks per-tree occupancy against the tree capacity, and drops illegal requests: push to a full tree, or pop from an empty tree. It issues at most one single-cycle push or pop per clock and honours the PIFO's `o_task_fifo_full` backpressure.

---
 rtl/pifo_req_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_pifo_req_dispatcher.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_req_dispatcher.sv
// Request front end for one PIFO level port: in-order request queue, per-tree
// occupancy tracking, illegal-request dropping and task-FIFO backpressure.
module pifo_req_dispatcher #(
    parameter int PTW           = 16,
    parameter int LEVEL         = 5,
    parameter int TREE_NUM      = 10,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int CAP           = 2**(LEVEL+1)-2,
    parameter int QDEPTH        = 4,
    parameter int OCW           = $clog2(CAP+1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_op,
    input  logic [TREE_NUM_BITS-1:0] i_req_tree_id,
    input  logic [PTW-1:0]           i_req_data,
    output logic                     o_push,
    output logic                     o_pop,
    output logic [TREE_NUM_BITS-1:0] o_tree_id,
    output logic [PTW-1:0]           o_push_data,
    input  logic                     i_task_fifo_full,
    output logic                     o_drop,
    output logic [TREE_NUM_BITS-1:0] o_drop_tree_id,
    input  logic [TREE_NUM_BITS-1:0] i_occ_tree_id,
    output logic [OCW-1:0]           o_occ
);

    localparam int             QAW   = $clog2(QDEPTH);
    localparam logic [QAW:0]   QFULL = (QAW+1)'(QDEPTH);
    localparam logic [OCW-1:0] CAP_V = OCW'(CAP);

    // Request queue storage and control
    logic                     q_op   [QDEPTH];
    logic [TREE_NUM_BITS-1:0] q_tree [QDEPTH];
    logic [PTW-1:0]           q_data [QDEPTH];
    logic [QAW-1:0]           wr_ptr;
    logic [QAW-1:0]           rd_ptr;
    logic [QAW:0]             count;

    logic q_full;
    logic q_empty;
    logic enq;
    logic deq;

    // Head-of-queue decode
    logic                     head_op;
    logic [TREE_NUM_BITS-1:0] head_tree;
    logic [PTW-1:0]           head_data;
    logic                     head_tree_ok;
    logic [OCW-1:0]           head_occ;
    logic                     issue_push;
    logic                     issue_pop;
    logic                     issue_drop;

    logic [OCW-1:0] occ [TREE_NUM];

    // Ready depends only on registered queue state, never on i_req_valid.
    assign q_full      = (count == QFULL);
    assign q_empty     = (count == '0);
    assign o_req_ready = !q_full && !i_rst;
    assign enq         = i_req_valid && o_req_ready;
    assign deq         = !q_empty && !i_task_fifo_full;

    assign head_op      = q_op[rd_ptr];
    assign head_tree    = q_tree[rd_ptr];
    assign head_data    = q_data[rd_ptr];
    assign head_tree_ok = (32'(head_tree) < TREE_NUM);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        head_occ = '0;
        if (head_tree_ok) begin
            head_occ = occ[head_tree];
        end
    end

    // A tree id outside 0..TREE_NUM-1 has no counter and is treated as illegal.
    always_comb begin
        issue_push = 1'b0;
        issue_pop  = 1'b0;
        issue_drop = 1'b0;
        if (deq) begin
            if (!head_op && head_tree_ok && (head_occ < CAP_V)) begin
                issue_push = 1'b1;
            end else if (head_op && head_tree_ok && (head_occ != '0)) begin
                issue_pop = 1'b1;
            end else begin
                issue_drop = 1'b1;
            end
        end
    end

    // NOTE: payload storage carries no reset; count alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            q_op[wr_ptr]   <= i_req_op;
            q_tree[wr_ptr] <= i_req_tree_id;
            q_data[wr_ptr] <= i_req_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + QAW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + QAW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (QAW+1)'(1);
                2'b01:   count <= count - (QAW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < TREE_NUM; t++) begin
                occ[t] <= '0;
            end
        end else if (issue_push) begin
            occ[head_tree] <= head_occ + OCW'(1);
        end else if (issue_pop) begin
            occ[head_tree] <= head_occ - OCW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_push         <= 1'b0;
            o_pop          <= 1'b0;
            o_drop         <= 1'b0;
            o_tree_id      <= '0;
            o_push_data    <= '0;
            o_drop_tree_id <= '0;
        end else begin
            o_push         <= issue_push;
            o_pop          <= issue_pop;
            o_drop         <= issue_drop;
            o_tree_id      <= (issue_push || issue_pop) ? head_tree : '0;
            o_push_data    <= issue_push ? head_data : '0;
            o_drop_tree_id <= issue_drop ? head_tree : '0;
        end
    end

    always_comb begin
        o_occ = '0;
        if (32'(i_occ_tree_id) < TREE_NUM) begin
            o_occ = occ[i_occ_tree_id];
        end
    end

endmodule

// File: tb/tb_pifo_req_dispatcher.sv
// Self-checking bench for pifo_req_dispatcher: scenario tasks compare the issued
// op stream against an in-order occupancy model of the accepted requests.
module tb_pifo_req_dispatcher;

    localparam int PTW      = 16;
    localparam int LEVEL    = 5;
    localparam int TREE_NUM = 10;
    localparam int TB       = 4;
    localparam int CAP      = 62;
    localparam int QDEPTH   = 4;
    localparam int OCW      = 6;

    logic           i_clk;
    logic           i_rst;
    logic           i_req_valid;
    logic           o_req_ready;
    logic           i_req_op;
    logic [TB-1:0]  i_req_tree_id;
    logic [PTW-1:0] i_req_data;
    logic           o_push;
    logic           o_pop;
    logic [TB-1:0]  o_tree_id;
    logic [PTW-1:0] o_push_data;
    logic           i_task_fifo_full;
    logic           o_drop;
    logic [TB-1:0]  o_drop_tree_id;
    logic [TB-1:0]  i_occ_tree_id;
    logic [OCW-1:0] o_occ;

    pifo_req_dispatcher #(
        .PTW(PTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .TREE_NUM_BITS(TB),
        .CAP(CAP), .QDEPTH(QDEPTH), .OCW(OCW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_tree_id(i_req_tree_id), .i_req_data(i_req_data),
        .o_push(o_push), .o_pop(o_pop), .o_tree_id(o_tree_id), .o_push_data(o_push_data),
        .i_task_fifo_full(i_task_fifo_full),
        .o_drop(o_drop), .o_drop_tree_id(o_drop_tree_id),
        .i_occ_tree_id(i_occ_tree_id), .o_occ(o_occ)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef enum int {EV_PUSH, EV_POP, EV_DROP} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       tree;
        int       data;
        int       cyc;
        int       occ;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];
    int  mocc [TREE_NUM];
    int  cyc = 0;
    int  viol = 0;
    int  checks = 0;
    int  failures = 0;
    bit  bp_run = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: records issued ops and counts protocol violations.
    always @(negedge i_clk) begin
        if (int'(o_push) + int'(o_pop) + int'(o_drop) > 1) viol++;
        if (!o_push && !o_pop && (o_tree_id != 0 || o_push_data != 0)) viol++;
        if (o_pop && o_push_data != 0) viol++;
        if (!o_drop && o_drop_tree_id != 0) viol++;
        if (o_push) obs.push_back('{EV_PUSH, int'(o_tree_id), int'(o_push_data), cyc, int'(o_occ)});
        if (o_pop)  obs.push_back('{EV_POP, int'(o_tree_id), 0, cyc, int'(o_occ)});
        if (o_drop) obs.push_back('{EV_DROP, int'(o_drop_tree_id), 0, cyc, int'(o_occ)});
    end

    // Reference model: requests are served strictly in order, so the expected
    // outcome of each request is fixed at the moment it is accepted.
    function automatic void model_accept(bit op, int tree, int data);
        if (!op && mocc[tree] < CAP) begin
            mocc[tree]++;
            exp_q.push_back('{EV_PUSH, tree, data, 0, 0});
        end else if (op && mocc[tree] > 0) begin
            mocc[tree]--;
            exp_q.push_back('{EV_POP, tree, 0, 0, 0});
        end else begin
            exp_q.push_back('{EV_DROP, tree, 0, 0, 0});
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs[i].kind != exp_q[i].kind || obs[i].tree != exp_q[i].tree ||
                obs[i].data != exp_q[i].data) return i;
        end
        if (obs.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic string ev_str(int idx, bit from_obs);
        ev_t e;
        if (from_obs) begin
            if (idx >= obs.size()) return "none";
            e = obs[idx];
        end else begin
            if (idx >= exp_q.size()) return "none";
            e = exp_q[idx];
        end
        return $sformatf("%s tree=%0d data=%0d", e.kind.name(), e.tree, e.data);
    endfunction

    // All driving tasks start and end just after a falling edge.
    task automatic send(input bit op, input int tree, input int data, input int budget,
                        output bit ok, output int acc_cyc);
        int w;
        w = 0;
        ok = 1'b0;
        acc_cyc = -1;
        i_req_valid   = 1'b1;
        i_req_op      = op;
        i_req_tree_id = TB'(tree);
        i_req_data    = PTW'(data);
        while (!o_req_ready && w < budget) begin
            @(negedge i_clk);
            w++;
        end
        if (o_req_ready) begin
            @(posedge i_clk);
            @(negedge i_clk);
            ok = 1'b1;
            acc_cyc = cyc;
            model_accept(op, tree, data);
        end
        i_req_valid   = 1'b0;
        i_req_op      = 1'b0;
        i_req_tree_id = '0;
        i_req_data    = '0;
    endtask

    task automatic drain(output bit timed_out);
        int n;
        n = 0;
        while (obs.size() < exp_q.size() && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        repeat (4) @(negedge i_clk);
        timed_out = (obs.size() < exp_q.size());
    endtask

    task automatic clear_model();
        for (int t = 0; t < TREE_NUM; t++) mocc[t] = 0;
        exp_q.delete();
        obs.delete();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        clear_model();
    endtask

    task automatic check_stream(input string name);
        bit to;
        int d;
        drain(to);
        checks++;
        if (to !== 1'b0) begin
            failures++;
            $display("FAIL %s drain: observed %0d ops, required %0d", name, obs.size(), exp_q.size());
        end
        d = first_diff();
        checks++;
        if (d !== -1) begin
            failures++;
            $display("FAIL %s stream at op %0d: got %s, required %s (counts %0d vs %0d)",
                     name, d, ev_str(d, 1'b1), ev_str(d, 1'b0), obs.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1;
        i_req_valid = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset ready: got %b, required 0", o_req_ready);
        end
        checks++;
        if ({o_push, o_pop, o_drop, o_tree_id, o_drop_tree_id, o_push_data} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got push=%b pop=%b drop=%b tree=%0d dtree=%0d data=%0h, required all 0",
                     o_push, o_pop, o_drop, o_tree_id, o_drop_tree_id, o_push_data);
        end
        i_rst = 1'b0;
        i_req_valid = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset release ready: got %b, required 1", o_req_ready);
        end
        bad = 0;
        for (int t = 0; t < TREE_NUM; t++) begin
            i_occ_tree_id = TB'(t);
            #1;
            if (o_occ !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset occ: %0d trees nonzero, required 0", bad);
        end
        @(negedge i_clk);
        clear_model();
    endtask

    task automatic test_empty_pop();
        bit ok;
        int ac;
        send(1'b1, 7, 0, 20, ok, ac);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL empty_pop accept: got %b, required 1", ok);
        end
        check_stream("empty_pop");
        i_occ_tree_id = 4'd7;
        #1;
        checks++;
        if (o_occ !== 6'd0) begin
            failures++;
            $display("FAIL empty_pop occ7: got %0d, required 0", o_occ);
        end
        @(negedge i_clk);
    endtask

    task automatic test_fill();
        bit ok;
        int ac;
        int rej;
        rej = 0;
        for (int i = 0; i < 63; i++) begin
            send(1'b0, 3, 4096*3 + (i % 62), 20, ok, ac);
            if (!ok) rej++;
        end
        checks++;
        if (rej !== 0) begin
            failures++;
            $display("FAIL fill accept: %0d rejected, required 0", rej);
        end
        check_stream("fill");
        i_occ_tree_id = 4'd3;
        #1;
        checks++;
        if (o_occ !== 6'd62) begin
            failures++;
            $display("FAIL fill occ3: got %0d, required 62", o_occ);
        end
        @(negedge i_clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int ac;
        int acc;
        int bad;
        acc = 0;
        i_task_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, $urandom_range(0, TREE_NUM-1), $urandom_range(0, 65535), 3, ok, ac);
            if (ok) acc++;
        end
        checks++;
        if (acc !== QDEPTH) begin
            failures++;
            $display("FAIL backpressure accepted: got %0d, required %0d", acc, QDEPTH);
        end
        checks++;
        if (o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure ready: got %b, required 0", o_req_ready);
        end
        repeat (5) @(negedge i_clk);
        checks++;
        if (obs.size() !== 0) begin
            failures++;
            $display("FAIL backpressure stalled issue: got %0d ops, required 0", obs.size());
        end
        i_task_fifo_full = 1'b0;
        check_stream("backpressure");
        bad = 0;
        for (int i = 1; i < obs.size(); i++) begin
            if (obs[i].cyc != obs[0].cyc + i) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL backpressure consecutive: %0d gaps, required 0", bad);
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure ready after drain: got %b, required 1", o_req_ready);
        end
    endtask

    task automatic test_interleave();
        bit ok;
        int ac;
        int rej;
        int bad;
        int v0;
        rej = 0;
        v0 = viol;
        for (int grp = 0; grp < 4; grp++) begin
            for (int t = (grp % 2) * 5; t < (grp % 2) * 5 + 5; t++) begin
                for (int i = 0; i < CAP; i++) begin
                    send(grp >= 2, t, (grp >= 2) ? 0 : $urandom_range(0, 65535), 20, ok, ac);
                    if (!ok) rej++;
                end
            end
        end
        checks++;
        if (rej !== 0) begin
            failures++;
            $display("FAIL interleave accept: %0d rejected, required 0", rej);
        end
        check_stream("interleave");
        bad = 0;
        for (int t = 0; t < TREE_NUM; t++) begin
            i_occ_tree_id = TB'(t);
            #1;
            if (o_occ !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL interleave final occ: %0d trees nonzero, required 0", bad);
        end
        checks++;
        if (viol - v0 !== 0) begin
            failures++;
            $display("FAIL interleave protocol: %0d violating cycles, required 0", viol - v0);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_midstream();
        bit ok;
        int ac;
        int bad;
        i_task_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, $urandom_range(0, TREE_NUM-1), $urandom_range(1, 65535), 3, ok, ac);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_req_ready, o_push, o_pop, o_drop, o_tree_id, o_drop_tree_id, o_push_data} !== '0) begin
            failures++;
            $display("FAIL midreset outputs: got ready=%b push=%b pop=%b drop=%b, required all 0",
                     o_req_ready, o_push, o_pop, o_drop);
        end
        i_rst = 1'b0;
        i_task_fifo_full = 1'b0;
        @(negedge i_clk);
        clear_model();
        repeat (8) @(negedge i_clk);
        checks++;
        if (obs.size() !== 0) begin
            failures++;
            $display("FAIL midreset discarded: got %0d ops issued, required 0", obs.size());
        end
        bad = 0;
        for (int t = 0; t < TREE_NUM; t++) begin
            i_occ_tree_id = TB'(t);
            #1;
            if (o_occ !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midreset occ: %0d trees nonzero, required 0", bad);
        end
        @(negedge i_clk);
        send(1'b0, 5, 16'h5a5a, 20, ok, ac);
        check_stream("midreset_after");
    endtask

    task automatic test_throughput();
        bit ok;
        int ac;
        int first_acc;
        int bad_cyc;
        int bad_occ;
        first_acc = -1;
        i_occ_tree_id = 4'd1;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 1, 100 + i, 20, ok, ac);
            if (i == 0) first_acc = ac;
        end
        check_stream("throughput");
        // Accepted at edge N, dequeued at N+1, visible in the cycle after N+1.
        checks++;
        if (obs.size() == 0 || obs[0].cyc !== first_acc + 1) begin
            failures++;
            $display("FAIL throughput latency: first op cycle %0d, required %0d",
                     (obs.size() == 0) ? -1 : obs[0].cyc, first_acc + 1);
        end
        bad_cyc = 0;
        bad_occ = 0;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].cyc != obs[0].cyc + i) bad_cyc++;
            if (obs[i].occ != i + 1) bad_occ++;
        end
        checks++;
        if (bad_cyc !== 0) begin
            failures++;
            $display("FAIL throughput rate: %0d gaps, required 0", bad_cyc);
        end
        checks++;
        if (bad_occ !== 0) begin
            failures++;
            $display("FAIL throughput occ1 ramp: %0d wrong samples, required 0", bad_occ);
        end
    endtask

    task automatic test_random();
        bit ok;
        int ac;
        int rej;
        int bad;
        int v0;
        rej = 0;
        v0 = viol;
        bp_run = 1'b1;
        fork
            begin
                while (bp_run) begin
                    @(negedge i_clk);
                    i_task_fifo_full = ($urandom_range(0, 2) == 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 1) == 1, $urandom_range(0, 2), $urandom_range(0, 65535),
                 200, ok, ac);
            if (!ok) rej++;
        end
        bp_run = 1'b0;
        @(negedge i_clk);
        #1;
        i_task_fifo_full = 1'b0;
        checks++;
        if (rej !== 0) begin
            failures++;
            $display("FAIL random accept: %0d rejected, required 0", rej);
        end
        check_stream("random");
        bad = 0;
        for (int t = 0; t < TREE_NUM; t++) begin
            i_occ_tree_id = TB'(t);
            #1;
            if (int'(o_occ) !== mocc[t]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL random occ: %0d trees differ from model", bad);
        end
        checks++;
        if (viol - v0 !== 0) begin
            failures++;
            $display("FAIL random protocol: %0d violating cycles, required 0", viol - v0);
        end
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_op = 1'b0;
        i_req_tree_id = '0;
        i_req_data = '0;
        i_task_fifo_full = 1'b0;
        i_occ_tree_id = '0;
        @(negedge i_clk);
        test_reset();
        test_empty_pop();
        do_reset();
        test_fill();
        do_reset();
        test_backpressure();
        do_reset();
        test_interleave();
        do_reset();
        test_reset_midstream();
        do_reset();
        test_throughput();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
